// File: rtl/sh_rx_deframer.sv
// Receive deframer: gathers one packet of strobed comparator bits behind the shunt-sync stage,
// then presents the payload, the received CRC field and a CRC-8 verdict with a one-cycle valid.
module sh_rx_deframer #(
  parameter int                    PACKET_BITS = 64,
  parameter int                    CRC_BITS    = 8,
  parameter logic [CRC_BITS-1:0]   CRC_POLY    = 8'h07
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sh_en,
  input  logic                              fsm_rst,
  input  logic                              sh_en_done,
  input  logic                              RX,
  input  logic                              rx_bit,
  output logic [PACKET_BITS-CRC_BITS-1:0]   pkt_data,
  output logic [CRC_BITS-1:0]               pkt_crc,
  output logic                              crc_ok,
  output logic                              pkt_valid,
  output logic                              rx_abort,
  output logic                              rx_busy,
  output logic [6:0]                        bit_count
);

  localparam int               DATA_BITS  = PACKET_BITS - CRC_BITS;
  localparam logic [6:0]       DATA_COUNT = 7'(DATA_BITS);
  localparam logic [6:0]       LAST_COUNT = 7'(PACKET_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PACKET_BITS-1:0]    shift_q, shift_d;
  logic [CRC_BITS-1:0]       crc_q, crc_d;
  logic [6:0]                bit_count_q, bit_count_d;
  logic [DATA_BITS-1:0]      pkt_data_q, pkt_data_d;
  logic [CRC_BITS-1:0]       pkt_crc_q, pkt_crc_d;
  logic                      crc_ok_q, crc_ok_d;
  logic                      rx_abort_q, rx_abort_d;

  logic [PACKET_BITS-1:0]    shift_next;
  logic [CRC_BITS-1:0]       crc_next;
  logic                      feedback;

  always_comb begin
    shift_next = {shift_q[PACKET_BITS-2:0], rx_bit};
    feedback   = crc_q[CRC_BITS-1] ^ rx_bit;
    crc_next   = {crc_q[CRC_BITS-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);

    state_d     = state_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    bit_count_d = bit_count_q;
    pkt_data_d  = pkt_data_q;
    pkt_crc_d   = pkt_crc_q;
    crc_ok_d    = crc_ok_q;
    rx_abort_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fsm_rst && RX && sh_en_done) begin
          state_d     = SHIFT;
          shift_d     = '0;
          crc_d       = '0;
          bit_count_d = '0;
        end
      end
      SHIFT: begin
        // Abort outranks a re-arm, and a re-arm swallows a coincident strobe.
        if (!RX || !sh_en_done) begin
          state_d    = IDLE;
          rx_abort_d = 1'b1;
        end else if (fsm_rst) begin
          shift_d     = '0;
          crc_d       = '0;
          bit_count_d = '0;
        end else if (sh_en) begin
          shift_d     = shift_next;
          bit_count_d = bit_count_q + 7'd1;
          if (bit_count_q < DATA_COUNT) begin
            crc_d = crc_next;
          end
          // crc_q already covers the whole payload once the CRC field starts arriving.
          if (bit_count_q == LAST_COUNT) begin
            state_d    = DONE;
            pkt_data_d = shift_next[PACKET_BITS-1:CRC_BITS];
            pkt_crc_d  = shift_next[CRC_BITS-1:0];
            crc_ok_d   = (crc_q == shift_next[CRC_BITS-1:0]);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      crc_q       <= '0;
      bit_count_q <= '0;
      pkt_data_q  <= '0;
      pkt_crc_q   <= '0;
      crc_ok_q    <= 1'b0;
      rx_abort_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      bit_count_q <= bit_count_d;
      pkt_data_q  <= pkt_data_d;
      pkt_crc_q   <= pkt_crc_d;
      crc_ok_q    <= crc_ok_d;
      rx_abort_q  <= rx_abort_d;
    end
  end

  assign pkt_data  = pkt_data_q;
  assign pkt_crc   = pkt_crc_q;
  assign crc_ok    = crc_ok_q;
  assign pkt_valid = (state_q == DONE);
  assign rx_abort  = rx_abort_q;
  assign rx_busy   = (state_q == SHIFT);
  assign bit_count = bit_count_q;

endmodule
